// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use, jump-register and multicycle-unit stalls,
// branch flush priority, and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int JR_LAT   = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       PCSource1,
  input  logic             IsBranch2,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rt1,
  input  logic [4:0]       Rt2,
  input  logic [4:0]       RegWrAddr2,
  input  logic             MemRead2,
  input  logic             RegWr2,
  input  logic             MulStart1,
  input  logic             MulStart2,
  input  logic [4:0]       MulRd2,
  output logic             PCWrite,
  output logic [1:0]       Conf1,
  output logic [1:0]       Conf2,
  output logic             MulDone,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] LOAD_N = 3'(LOAD_LAT);
  localparam logic [2:0] JR_N   = 3'(JR_LAT);
  localparam logic [3:0] MUL_N  = 4'(MUL_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       busy;
  logic [3:0] mcnt;
  logic [4:0] mul_rd;

  logic       lu, jh, mh, stall;
  logic [2:0] n_lu, n_jh, n;

  assign lu = MemRead2 && (Rt2 != 5'd0) && ((Rt2 == Rs1) || (Rt2 == Rt1));
  assign jh = (PCSource1 == 2'b10) && RegWr2 && (RegWrAddr2 != 5'd0) && (RegWrAddr2 == Rs1);
  assign mh = busy && (((mul_rd != 5'd0) && ((Rs1 == mul_rd) || (Rt1 == mul_rd))) || MulStart1);
  assign stall = lu || jh || mh || (state == HOLD);

  assign n_lu = lu ? LOAD_N : 3'd0;
  assign n_jh = jh ? JR_N : 3'd0;
  assign n    = (n_lu > n_jh) ? n_lu : n_jh;

  assign MulDone = reset && busy && (mcnt == 4'd0);

  // Outputs follow the current-cycle hazard; a taken branch overrides any stall.
  always_comb begin
    PCWrite = 1'b1;
    Conf1   = 2'b00;
    Conf2   = 2'b00;
    if (reset) begin
      if (IsBranch2) begin
        Conf1 = 2'b10;
        Conf2 = 2'b10;
      end else if (stall) begin
        PCWrite = 1'b0;
        Conf1   = 2'b01;
        Conf2   = 2'b10;
      end
    end
  end

  // The first stall cycle is spent in IDLE, so HOLD covers the remaining N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (IsBranch2) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: if ((lu || jh) && (n > 3'd1)) begin
          state <= HOLD;
          cnt   <= n - 3'd2;
        end
        HOLD: if (cnt == 3'd0) state <= IDLE;
              else             cnt   <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      mcnt   <= 4'd0;
      mul_rd <= 5'd0;
    end else if (busy) begin
      if (mcnt == 4'd0) busy <= 1'b0;
      else              mcnt <= mcnt - 4'd1;
    end else if (MulStart2) begin
      busy   <= 1'b1;
      mul_rd <= MulRd2;
      mcnt   <= MUL_N;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             StallCount <= '0;
    else if (!PCWrite && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two parameterisations share one stimulus stream,
// each checked every cycle against a cycle-count model of the hazard rules.
module tb_hazard_scoreboard;
  localparam int LL[2] = '{1, 3};
  localparam int JL[2] = '{2, 4};
  localparam int ML[2] = '{4, 6};
  localparam int CW[2] = '{16, 4};

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] PCSource1;
  logic       IsBranch2, MemRead2, RegWr2, MulStart1, MulStart2;
  logic [4:0] Rs1, Rt1, Rt2, RegWrAddr2, MulRd2;
  logic       pcw[2];
  logic [1:0] c1[2], c2[2];
  logic       md[2];
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  int tests = 0, fails = 0;
  int hold_left[2], mul_left[2], scnt[2];
  logic [4:0] rd[2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.LOAD_LAT(LL[0]), .JR_LAT(JL[0]), .MUL_LAT(ML[0]), .CNT_W(CW[0])) dut_a (
    .clk(clk), .reset(reset), .PCSource1(PCSource1), .IsBranch2(IsBranch2), .Rs1(Rs1), .Rt1(Rt1),
    .Rt2(Rt2), .RegWrAddr2(RegWrAddr2), .MemRead2(MemRead2), .RegWr2(RegWr2), .MulStart1(MulStart1),
    .MulStart2(MulStart2), .MulRd2(MulRd2), .PCWrite(pcw[0]), .Conf1(c1[0]), .Conf2(c2[0]),
    .MulDone(md[0]), .StallCount(sc_a));

  hazard_scoreboard #(.LOAD_LAT(LL[1]), .JR_LAT(JL[1]), .MUL_LAT(ML[1]), .CNT_W(CW[1])) dut_b (
    .clk(clk), .reset(reset), .PCSource1(PCSource1), .IsBranch2(IsBranch2), .Rs1(Rs1), .Rt1(Rt1),
    .Rt2(Rt2), .RegWrAddr2(RegWrAddr2), .MemRead2(MemRead2), .RegWr2(RegWr2), .MulStart1(MulStart1),
    .MulStart2(MulStart2), .MulRd2(MulRd2), .PCWrite(pcw[1]), .Conf1(c1[1]), .Conf2(c2[1]),
    .MulDone(md[1]), .StallCount(sc_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sc_of(input int i);
    return (i == 0) ? {16'd0, sc_a} : {28'd0, sc_b};
  endfunction

  task automatic clr();
    PCSource1 = 2'b00; IsBranch2 = 0; MemRead2 = 0; RegWr2 = 0; MulStart1 = 0; MulStart2 = 0;
    Rs1 = 0; Rt1 = 0; Rt2 = 0; RegWrAddr2 = 0; MulRd2 = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hold_left[i] = 0; mul_left[i] = 0; scnt[i] = 0; rd[i] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_pcw%0d", tag, i), {31'd0, pcw[i]}, 32'd1);
      chk($sformatf("%s_c1_%0d", tag, i), {30'd0, c1[i]}, 32'd0);
      chk($sformatf("%s_c2_%0d", tag, i), {30'd0, c2[i]}, 32'd0);
      chk($sformatf("%s_md%0d", tag, i), {31'd0, md[i]}, 32'd0);
      chk($sformatf("%s_sc%0d", tag, i), sc_of(i), 32'd0);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    int nh[2], nm[2], ns[2];
    logic [4:0] nr[2];
    #3;
    for (int i = 0; i < 2; i++) begin
      bit lu, jh, mh, st, bsy;
      int n;
      logic ep, emd;
      logic [1:0] e1, e2;
      lu  = MemRead2 && Rt2 != 0 && (Rt2 == Rs1 || Rt2 == Rt1);
      jh  = PCSource1 == 2'b10 && RegWr2 && RegWrAddr2 != 0 && RegWrAddr2 == Rs1;
      bsy = mul_left[i] > 0;
      mh  = bsy && ((rd[i] != 0 && (Rs1 == rd[i] || Rt1 == rd[i])) || MulStart1);
      st  = lu || jh || mh || hold_left[i] > 0;
      if (IsBranch2) begin ep = 1; e1 = 2'b10; e2 = 2'b10; end
      else if (st)   begin ep = 0; e1 = 2'b01; e2 = 2'b10; end
      else           begin ep = 1; e1 = 2'b00; e2 = 2'b00; end
      emd = (mul_left[i] == 1);
      chk($sformatf("%s_pcw%0d", tag, i), {31'd0, pcw[i]}, {31'd0, ep});
      chk($sformatf("%s_c1_%0d", tag, i), {30'd0, c1[i]}, {30'd0, e1});
      chk($sformatf("%s_c2_%0d", tag, i), {30'd0, c2[i]}, {30'd0, e2});
      chk($sformatf("%s_md%0d", tag, i), {31'd0, md[i]}, {31'd0, emd});
      chk($sformatf("%s_sc%0d", tag, i), sc_of(i), scnt[i]);
      n = 0;
      if (lu && LL[i] > n) n = LL[i];
      if (jh && JL[i] > n) n = JL[i];
      if (IsBranch2)         nh[i] = 0;
      else if (hold_left[i] > 0) nh[i] = hold_left[i] - 1;
      else if (n > 0)        nh[i] = n - 1;
      else                   nh[i] = 0;
      nr[i] = rd[i];
      if (bsy) nm[i] = mul_left[i] - 1;
      else if (MulStart2) begin nm[i] = ML[i]; nr[i] = MulRd2; end
      else nm[i] = 0;
      ns[i] = (!ep && scnt[i] < (1 << CW[i]) - 1) ? scnt[i] + 1 : scnt[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      hold_left[i] = nh[i]; mul_left[i] = nm[i]; rd[i] = nr[i]; scnt[i] = ns[i];
    end
    #1;
  endtask

  task automatic idle(input string tag, input int k);
    clr();
    for (int j = 0; j < k; j++) cycle(tag);
  endtask

  // Asserted mid-cycle so the asynchronous path is exercised on its own.
  task automatic do_reset(input string tag);
    reset = 0;
    #1;
    model_reset();
    chk_reset_outputs(tag);
    @(posedge clk); #1;
    reset = 1;
  endtask

  initial begin
    clr();
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1;

    // Load-use on r8: one stall cycle for LOAD_LAT=1, three for LOAD_LAT=3
    MemRead2 = 1; Rt2 = 8; Rs1 = 8;
    cycle("lu");
    idle("lu_tail", 4);
    chk("lu_count_a", sc_of(0), 32'd1);
    chk("lu_count_b", sc_of(1), 32'd3);

    // r0 never hazards
    MemRead2 = 1; Rt2 = 0; Rs1 = 0; Rt1 = 0;
    cycle("r0");
    idle("r0_tail", 1);

    // Jump-register on r31
    PCSource1 = 2'b10; RegWr2 = 1; RegWrAddr2 = 31; Rs1 = 31;
    cycle("jr");
    idle("jr_tail", 5);
    chk("jr_count_a", sc_of(0), 32'd3);

    // Branch arriving in the second stall cycle wins and cancels the hold
    MemRead2 = 1; Rt2 = 9; Rt1 = 9;
    cycle("br_lu");
    clr(); IsBranch2 = 1;
    cycle("br_hit");
    idle("br_tail", 3);

    // Multicycle op to r5 followed by a dependent reader
    MulStart2 = 1; MulRd2 = 5;
    cycle("mul_start");
    clr(); Rs1 = 5;
    for (int j = 0; j < 8; j++) cycle("mul_dep");
    idle("mul_tail", 2);

    // Reset during HOLD and during a busy multicycle op
    MemRead2 = 1; Rt2 = 7; Rs1 = 7;
    cycle("hold_lu");
    clr();
    do_reset("rst_hold");
    idle("rst_hold_after", 4);
    MulStart2 = 1; MulRd2 = 3;
    cycle("busy_start");
    clr(); Rt1 = 3;
    cycle("busy_dep");
    do_reset("rst_busy");
    idle("rst_busy_after", 8);

    // Randomized traffic on a small register set so matches are frequent
    for (int j = 0; j < 400; j++) begin
      PCSource1  = 2'($urandom_range(0, 3));
      IsBranch2  = ($urandom_range(0, 9) == 0);
      MemRead2   = ($urandom_range(0, 2) == 0);
      RegWr2     = $urandom_range(0, 1) == 1;
      MulStart1  = ($urandom_range(0, 7) == 0);
      MulStart2  = ($urandom_range(0, 7) == 0);
      Rs1        = 5'($urandom_range(0, 3));
      Rt1        = 5'($urandom_range(0, 3));
      Rt2        = 5'($urandom_range(0, 3));
      RegWrAddr2 = 5'($urandom_range(0, 3));
      MulRd2     = 5'($urandom_range(0, 3));
      cycle("rand");
    end
    idle("end", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
